sound_square_v2: RTL and testbench
==================================

SOUND_SQUARE_V2 -- requirements
Module: sound_square_v2

Interface
REQ-001 Parameters: FREQ_W, default 11, frequency/divider width.
REQ-002 Parameters: DUTY_W, default 3, phase width; 2^DUTY_W steps per waveform period.
REQ-003 Parameters: LEN_W, default 6, length width.
REQ-004 Parameters: VOL_W, default 4, volume/level width.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 tick_freq, tick_length, tick_env, tick_sweep  in  1 each  one-cycle enable strobes in the clk domain.
REQ-008 trigger  in  1  one-cycle restart pulse; no edge detection inside.
REQ-009 frequency  in  FREQ_W  period = 2^DUTY_W*(2^FREQ_W - frequency) tick_freq strobes.
REQ-010 duty  in  DUTY_W  number of high phase steps per period.
REQ-011 sweep_period, sweep_shift  in  3 each; sweep_dir  in  1 (0 add, 1 subtract).
REQ-012 length_load  in  LEN_W; length_en  in  1.
REQ-013 init_vol  in  VOL_W; env_dir  in  1 (1 increase); env_period  in  3.
REQ-014 level  out  VOL_W  channel sample; enable  out  1  channel active; cur_freq  out  FREQ_W  swept frequency shadow.

Function
REQ-015 Priority per cycle: trigger over all ticks; with no trigger, ticks act independently and all in the same cycle.
REQ-016 Trigger: div<=frequency, phase<=0, shadow<=frequency, sweep_cnt<=sweep_period, vol<=init_vol, env_cnt<=env_period, enable<=1 unless DAC off (REQ-025).
REQ-016a Trigger with length counter 0: length counter<=2^LEN_W - length_load; with length counter nonzero: counter unchanged.
REQ-017 Divider: on tick_freq with enable=1 -- div==all-ones: div<=shadow, phase<=phase+1 mod 2^DUTY_W; otherwise div<=div+1.
REQ-018 Waveform: wave = (phase < duty); duty=0 always low.
REQ-019 Sweep, sweep_period=0: tick_sweep ignored.
REQ-020 Sweep, sweep_period!=0, on tick_sweep: sweep_cnt>1 -- decrement; sweep_cnt<=1 -- sweep_cnt<=sweep_period and compute new.
REQ-021 new = shadow + (shadow>>sweep_shift) at FREQ_W+1 bits for sweep_dir=0; shadow - (shadow>>sweep_shift) for sweep_dir=1, which cannot underflow.
REQ-022 Add overflow (bit FREQ_W set): enable<=0, shadow unchanged; otherwise with sweep_shift!=0: shadow<=new; with sweep_shift=0: shadow unchanged.
REQ-023 Envelope, env_period!=0, on tick_env: env_cnt>1 -- decrement; else reload env_cnt and step vol by +/-1, saturating at 0 and 2^VOL_W-1.
REQ-024 Length: on tick_length with length_en=1 and counter!=0, decrement; transition to 0 sets enable<=0; counter width LEN_W+1.
REQ-025 DAC off (init_vol==0 and env_dir==0): enable forced 0 the next cycle and trigger cannot set it.
REQ-026 level = (enable & wave) ? vol : 0; combinational from registers; one-cycle latency from any causing edge.
REQ-027 cur_freq = shadow at all times.
REQ-028 Input changes other than trigger: no effect on running shadow/vol until the next trigger, except duty, sweep_*, env_period and length_en, which take effect immediately.

Reset
REQ-029 rst low: asynchronously clears div, phase, shadow, sweep_cnt, vol, env_cnt, length counter and enable to 0; level=0, cur_freq=0.
REQ-030 rst held low: all strobes and trigger ignored.
REQ-031 rst release: channel idle until first trigger.

Verification
REQ-032 Duty/period: frequency=2047, duty=4, init_vol=9, trigger, then tick_freq every cycle -> level 9 for 4 cycles, 0 for 4, repeating with period 8.
REQ-033 Sweep overflow: frequency=1792, shift=1, dir=0, sweep_period=1, trigger, one tick_sweep -> enable=0, level=0, cur_freq stays 1792.
REQ-034 Sweep subtract: frequency=1024, shift=2, dir=1, sweep_period=2 -> cur_freq 768 after the 2nd tick_sweep, 576 after the 4th.
REQ-035 Length: length_load=62, length_en=1, trigger -> enable drops on the 2nd tick_length; retrigger -> counter reloaded to 2.
REQ-036 Envelope: init_vol=3, env_dir=0, env_period=1 -> vol 2,1,0 after 3 tick_env, stays 0; init_vol=15, env_dir=1 -> stays 15.
REQ-037 Reset/priority: trigger and tick_freq in the same cycle -> phase=0, div=frequency; rst low mid-playback -> level=0, enable=0 before the next clk edge.

Source files
------------

// File: rtl/sound_square_v2.sv
// Purpose: square-wave sound channel with duty, sweep, envelope and length units.
// Latency: level_o/enable_o/cur_freq_o follow registered state one cycle after the causing edge.
// Backpressure: none; strobes are one-cycle enables and are never stalled.
module sound_square_v2 #(
   parameter int FREQ_W = 11,
   parameter int DUTY_W = 3,
   parameter int LEN_W  = 6,
   parameter int VOL_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tick_freq_i,
   input  logic              tick_length_i,
   input  logic              tick_env_i,
   input  logic              tick_sweep_i,
   input  logic              trigger_i,
   input  logic [FREQ_W-1:0] frequency_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [2:0]        sweep_period_i,
   input  logic [2:0]        sweep_shift_i,
   input  logic              sweep_dir_i,
   input  logic [LEN_W-1:0]  length_load_i,
   input  logic              length_en_i,
   input  logic [VOL_W-1:0]  init_vol_i,
   input  logic              env_dir_i,
   input  logic [2:0]        env_period_i,
   output logic [VOL_W-1:0]  level_o,
   output logic              enable_o,
   output logic [FREQ_W-1:0] cur_freq_o
);

   // Length counter is one bit wider so a load of 0 yields the full 2^LEN_W count.
   localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};
   localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

   logic [FREQ_W-1:0] div_q, div_d;
   logic [DUTY_W-1:0] phase_q, phase_d;
   logic [FREQ_W-1:0] shadow_q, shadow_d;
   logic [2:0]        sweep_cnt_q, sweep_cnt_d;
   logic [VOL_W-1:0]  vol_q, vol_d;
   logic [2:0]        env_cnt_q, env_cnt_d;
   logic              env_dir_q, env_dir_d;
   logic [LEN_W:0]    len_q, len_d;
   logic              enable_q, enable_d;

   logic              dac_off;
   logic              wave;
   logic [FREQ_W-1:0] sweep_delta;
   logic [FREQ_W:0]   sweep_new;

   // DAC is powered down when the envelope can only stay at or fall to zero.
   assign dac_off     = (init_vol_i == '0) && !env_dir_i;
   assign sweep_delta = shadow_q >> sweep_shift_i;
   // Subtract path cannot borrow since the delta never exceeds the shadow.
   assign sweep_new   = sweep_dir_i ? ({1'b0, shadow_q} - {1'b0, sweep_delta})
                                    : ({1'b0, shadow_q} + {1'b0, sweep_delta});

   assign wave       = (phase_q < duty_i);
   assign level_o    = (enable_q && wave) ? vol_q : '0;
   assign enable_o   = enable_q;
   assign cur_freq_o = shadow_q;

   // Next-state: trigger restarts every unit; otherwise each strobe acts on its own unit.
   always_comb begin
      div_d       = div_q;
      phase_d     = phase_q;
      shadow_d    = shadow_q;
      sweep_cnt_d = sweep_cnt_q;
      vol_d       = vol_q;
      env_cnt_d   = env_cnt_q;
      env_dir_d   = env_dir_q;
      len_d       = len_q;
      enable_d    = enable_q;

      if (trigger_i) begin
         div_d       = frequency_i;
         phase_d     = '0;
         shadow_d    = frequency_i;
         sweep_cnt_d = sweep_period_i;
         vol_d       = init_vol_i;
         env_cnt_d   = env_period_i;
         env_dir_d   = env_dir_i;
         enable_d    = 1'b1;
         if (len_q == '0) begin
            len_d = LEN_FULL - {1'b0, length_load_i};
         end
      end else begin
         if (tick_freq_i && enable_q) begin
            if (&div_q) begin
               div_d   = shadow_q;
               phase_d = phase_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         if (tick_sweep_i && (sweep_period_i != 3'd0)) begin
            if (sweep_cnt_q > 3'd1) begin
               sweep_cnt_d = sweep_cnt_q - 3'd1;
            end else begin
               sweep_cnt_d = sweep_period_i;
               if (sweep_new[FREQ_W]) begin
                  enable_d = 1'b0;
               end else if (sweep_shift_i != 3'd0) begin
                  shadow_d = sweep_new[FREQ_W-1:0];
               end
            end
         end

         if (tick_env_i && (env_period_i != 3'd0)) begin
            if (env_cnt_q > 3'd1) begin
               env_cnt_d = env_cnt_q - 3'd1;
            end else begin
               env_cnt_d = env_period_i;
               if (env_dir_q) begin
                  if (vol_q != VOL_MAX) vol_d = vol_q + 1'b1;
               end else begin
                  if (vol_q != '0) vol_d = vol_q - 1'b1;
               end
            end
         end

         if (tick_length_i && length_en_i && (len_q != '0)) begin
            len_d = len_q - 1'b1;
            if (len_q == {{LEN_W{1'b0}}, 1'b1}) enable_d = 1'b0;
         end
      end

      // A powered-down DAC overrides every other enable source, trigger included.
      if (dac_off) enable_d = 1'b0;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q       <= '0;
         phase_q     <= '0;
         shadow_q    <= '0;
         sweep_cnt_q <= '0;
         vol_q       <= '0;
         env_cnt_q   <= '0;
         env_dir_q   <= 1'b0;
         len_q       <= '0;
         enable_q    <= 1'b0;
      end else begin
         div_q       <= div_d;
         phase_q     <= phase_d;
         shadow_q    <= shadow_d;
         sweep_cnt_q <= sweep_cnt_d;
         vol_q       <= vol_d;
         env_cnt_q   <= env_cnt_d;
         env_dir_q   <= env_dir_d;
         len_q       <= len_d;
         enable_q    <= enable_d;
      end
   end

endmodule

// File: tb/tb_sound_square_v2.sv
// Purpose: directed self-checking bench for the square-wave sound channel.
// Latency: outputs are sampled 1 ns after each rising clock edge.
// Backpressure: not applicable; stimulus is fixed directed vectors.
module tb_sound_square_v2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        tick_freq_i, tick_length_i, tick_env_i, tick_sweep_i, trigger_i;
   logic [10:0] frequency_i;
   logic [2:0]  duty_i;
   logic [2:0]  sweep_period_i, sweep_shift_i;
   logic        sweep_dir_i;
   logic [5:0]  length_load_i;
   logic        length_en_i;
   logic [3:0]  init_vol_i;
   logic        env_dir_i;
   logic [2:0]  env_period_i;
   logic [3:0]  level_o;
   logic        enable_o;
   logic [10:0] cur_freq_o;

   int total = 0;
   int bad   = 0;

   sound_square_v2 dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .tick_freq_i(tick_freq_i), .tick_length_i(tick_length_i),
      .tick_env_i(tick_env_i), .tick_sweep_i(tick_sweep_i), .trigger_i(trigger_i),
      .frequency_i(frequency_i), .duty_i(duty_i),
      .sweep_period_i(sweep_period_i), .sweep_shift_i(sweep_shift_i), .sweep_dir_i(sweep_dir_i),
      .length_load_i(length_load_i), .length_en_i(length_en_i),
      .init_vol_i(init_vol_i), .env_dir_i(env_dir_i), .env_period_i(env_period_i),
      .level_o(level_o), .enable_o(enable_o), .cur_freq_o(cur_freq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      tick_freq_i = 0; tick_length_i = 0; tick_env_i = 0; tick_sweep_i = 0; trigger_i = 0;
      frequency_i = 0; duty_i = 0; sweep_period_i = 0; sweep_shift_i = 0; sweep_dir_i = 0;
      length_load_i = 0; length_en_i = 0; init_vol_i = 0; env_dir_i = 0; env_period_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_ni = 0;
      cyc();
      rst_ni = 1;
      cyc();
   endtask

   task automatic trig();
      trigger_i = 1;
      cyc();
      trigger_i = 0;
   endtask

   task automatic pulse_sweep();
      tick_sweep_i = 1; cyc(); tick_sweep_i = 0;
   endtask

   task automatic pulse_env();
      tick_env_i = 1; cyc(); tick_env_i = 0;
   endtask

   task automatic pulse_len();
      tick_length_i = 1; cyc(); tick_length_i = 0;
   endtask

   initial begin
      clear_inputs();
      rst_ni = 0;
      #2;
      // Reset state and strobes ignored while held in reset.
      chk("rst_level", level_o, 0);
      chk("rst_enable", enable_o, 0);
      chk("rst_cur_freq", cur_freq_o, 0);
      frequency_i = 11'd1000; init_vol_i = 4'd9; duty_i = 3'd4;
      trigger_i = 1; tick_freq_i = 1;
      cyc(); cyc();
      chk("rst_held_trig_enable", enable_o, 0);
      chk("rst_held_trig_freq", cur_freq_o, 0);
      trigger_i = 0; tick_freq_i = 0;
      rst_ni = 1;
      cyc(); cyc();
      chk("idle_after_release", enable_o, 0);

      // Duty/period: level 9 for 4 steps, 0 for 4, period 8.
      do_reset();
      frequency_i = 11'd2047; duty_i = 3'd4; init_vol_i = 4'd9;
      trig();
      tick_freq_i = 1;
      chk("duty_enable", enable_o, 1);
      chk("duty_ph0", level_o, 9);
      for (int i = 1; i <= 16; i++) begin
         cyc();
         chk($sformatf("duty_ph%0d", i), level_o, ((i % 8) < 4) ? 9 : 0);
      end
      tick_freq_i = 0;
      duty_i = 3'd0;
      #1;
      chk("duty_zero", level_o, 0);
      duty_i = 3'd7;
      #1;
      chk("duty_seven", level_o, 9);

      // Sweep overflow disables channel, shadow keeps 1792.
      do_reset();
      frequency_i = 11'd1792; sweep_shift_i = 3'd1; sweep_dir_i = 0; sweep_period_i = 3'd1;
      duty_i = 3'd4; init_vol_i = 4'd9;
      trig();
      chk("ovf_pre_level", level_o, 9);
      chk("ovf_pre_freq", cur_freq_o, 1792);
      pulse_sweep();
      chk("ovf_enable", enable_o, 0);
      chk("ovf_level", level_o, 0);
      chk("ovf_freq", cur_freq_o, 1792);

      // Sweep subtract: 1024 -> 768 -> 576 every second tick.
      do_reset();
      frequency_i = 11'd1024; sweep_shift_i = 3'd2; sweep_dir_i = 1; sweep_period_i = 3'd2;
      duty_i = 3'd4; init_vol_i = 4'd9;
      trig();
      pulse_sweep();
      chk("sub_t1", cur_freq_o, 1024);
      pulse_sweep();
      chk("sub_t2", cur_freq_o, 768);
      pulse_sweep();
      chk("sub_t3", cur_freq_o, 768);
      pulse_sweep();
      chk("sub_t4", cur_freq_o, 576);
      chk("sub_enable", enable_o, 1);

      // Shift 0: no overflow, shadow unchanged; period 0: tick ignored.
      do_reset();
      frequency_i = 11'd500; sweep_shift_i = 3'd0; sweep_period_i = 3'd1;
      duty_i = 3'd4; init_vol_i = 4'd9;
      trig();
      pulse_sweep();
      chk("shift0_freq", cur_freq_o, 500);
      chk("shift0_enable", enable_o, 1);
      sweep_shift_i = 3'd1; sweep_period_i = 3'd0;
      pulse_sweep();
      chk("period0_freq", cur_freq_o, 500);

      // Envelope down to 0 and saturate; up saturates at 15.
      do_reset();
      init_vol_i = 4'd3; env_dir_i = 0; env_period_i = 3'd1; duty_i = 3'd4;
      frequency_i = 11'd100;
      trig();
      chk("env_v3", level_o, 3);
      pulse_env(); chk("env_v2", level_o, 2);
      pulse_env(); chk("env_v1", level_o, 1);
      pulse_env(); chk("env_v0", level_o, 0);
      pulse_env(); chk("env_v0_hold", level_o, 0);
      chk("env_v0_enable", enable_o, 1);
      do_reset();
      init_vol_i = 4'd15; env_dir_i = 1; env_period_i = 3'd1; duty_i = 3'd4;
      trig();
      pulse_env(); pulse_env();
      chk("env_sat15", level_o, 15);
      do_reset();
      init_vol_i = 4'd5; env_dir_i = 1; env_period_i = 3'd2; duty_i = 3'd4;
      trig();
      pulse_env(); chk("env_p2_t1", level_o, 5);
      pulse_env(); chk("env_p2_t2", level_o, 6);

      // Length: load 62 -> 2 ticks; retrigger reloads at 0, keeps count when nonzero.
      do_reset();
      length_load_i = 6'd62; length_en_i = 1; init_vol_i = 4'd9; duty_i = 3'd4;
      frequency_i = 11'd100;
      trig();
      pulse_len(); chk("len_t1", enable_o, 1);
      pulse_len(); chk("len_t2", enable_o, 0);
      pulse_len(); chk("len_t3", enable_o, 0);
      trig();
      chk("len_retrig", enable_o, 1);
      pulse_len(); chk("len_re_t1", enable_o, 1);
      trig();
      pulse_len(); chk("len_keep_t1", enable_o, 0);
      trig();
      length_en_i = 0;
      pulse_len(); pulse_len(); pulse_len();
      chk("len_disabled", enable_o, 1);

      // DAC off: trigger cannot enable; live change drops enable next cycle.
      do_reset();
      init_vol_i = 4'd0; env_dir_i = 0; frequency_i = 11'd100; duty_i = 3'd4;
      trig();
      chk("dac_off_trig", enable_o, 0);
      env_dir_i = 1;
      trig();
      chk("dac_on_trig", enable_o, 1);
      env_dir_i = 0;
      cyc();
      chk("dac_off_live", enable_o, 0);

      // Trigger beats tick_freq; async reset clears outputs before next edge.
      do_reset();
      frequency_i = 11'd2046; duty_i = 3'd1; init_vol_i = 4'd9;
      trigger_i = 1; tick_freq_i = 1;
      cyc();
      trigger_i = 0;
      chk("prio_ph0", level_o, 9);
      cyc();
      chk("prio_div_inc", level_o, 9);
      cyc();
      chk("prio_ph1", level_o, 0);
      tick_freq_i = 0;
      duty_i = 3'd2;
      #1;
      chk("prio_live_duty", level_o, 9);
      rst_ni = 0;
      #2;
      chk("async_rst_level", level_o, 0);
      chk("async_rst_enable", enable_o, 0);
      chk("async_rst_freq", cur_freq_o, 0);
      rst_ni = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
